// File: rtl/dtmf_pkg.sv
// DTMF shared definitions: tone half-period tables, sequencer states, key split helpers.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package dtmf_pkg;

  localparam int NOM_CLK_HZ = 1000000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TONE = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Half-period in clocks, rounded to nearest: round(clk_hz / (2*freq)).
  function automatic logic [9:0] half_of(input int clk_hz, input int freq);
    int h;
    h = (clk_hz + freq) / (2 * freq);
    return h[9:0];
  endfunction

  function automatic logic [9:0] row_half(input int clk_hz, input int r);
    int f;
    case (r)
      0:       f = 697;
      1:       f = 770;
      2:       f = 852;
      default: f = 941;
    endcase
    return half_of(clk_hz, f);
  endfunction

  function automatic logic [9:0] col_half(input int clk_hz, input int c);
    int f;
    case (c)
      0:       f = 1209;
      1:       f = 1336;
      2:       f = 1477;
      default: f = 1633;
    endcase
    return half_of(clk_hz, f);
  endfunction

  // Tables at the 1 MHz lab clock: rows 717/649/587/531, cols 414/374/339/306.
  localparam logic [9:0] ROW_HALF [4] = '{row_half(NOM_CLK_HZ, 0), row_half(NOM_CLK_HZ, 1),
                                          row_half(NOM_CLK_HZ, 2), row_half(NOM_CLK_HZ, 3)};
  localparam logic [9:0] COL_HALF [4] = '{col_half(NOM_CLK_HZ, 0), col_half(NOM_CLK_HZ, 1),
                                          col_half(NOM_CLK_HZ, 2), col_half(NOM_CLK_HZ, 3)};

  // key_code = row*4 + col
  function automatic logic [1:0] key_row(input logic [3:0] code);
    return code[3:2];
  endfunction

  function automatic logic [1:0] key_col(input logic [3:0] code);
    return code[1:0];
  endfunction

endpackage

// File: rtl/dtmf_tone_sequencer_if.sv
// Keypad request channel: 4-bit key index with valid/ready handshake.
// Latency: n/a (wires only).
// Backpressure: key_valid is held by the source until key_ready is seen high at a clock edge.
interface dtmf_tone_sequencer_if;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;

  modport master (output key_code, output key_valid, input key_ready);
  modport slave  (input key_code, input key_valid, output key_ready);
endinterface

// File: rtl/tone_divider.sv
// Square-wave divider: toggles tone every `half` enabled clocks (period 2*half).
// Latency: first toggle `half` clocks after en rises; en low clears counter and output next edge.
// Backpressure: none.
// Ports: inclk/reset_n clock and async reset, en run enable, half half-period in clocks, tone output.
module tone_divider (
  input  logic       inclk,
  input  logic       reset_n,
  input  logic       en,
  input  logic [9:0] half,
  output logic       tone
);

  logic [9:0] cnt;

  // Wrap at half-1 so the toggle lands on the edge where the count would reach half.
  always_ff @(posedge inclk or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      tone <= 1'b0;
    end else if (!en) begin
      cnt  <= '0;
      tone <= 1'b0;
    end else if (cnt == half - 10'd1) begin
      cnt  <= '0;
      tone <= ~tone;
    end else begin
      cnt <= cnt + 10'd1;
    end
  end

endmodule

// File: rtl/dtmf_tone_sequencer.sv
// DTMF sequencer: accepts a key, plays row+col square waves for TONE_MS, then a silent GAP_MS.
// Latency: tone starts the edge after acceptance; done pulses (TONE_MS+GAP_MS)*MS_DIV clocks after it.
// Backpressure: key_ready only in IDLE with abort low; keys offered while busy are dropped, not queued.
// Ports: inclk/reset_n, key (slave handshake), abort, row_tone/col_tone, tone_active, busy, done.
module dtmf_tone_sequencer
  import dtmf_pkg::*;
#(
  parameter int CLK_HZ  = 1000000,
  parameter int MS_DIV  = CLK_HZ / 1000,
  parameter int TONE_MS = 100,
  parameter int GAP_MS  = 50
) (
  input  logic                    inclk,
  input  logic                    reset_n,
  dtmf_tone_sequencer_if.slave    key,
  input  logic                    abort,
  output logic                    row_tone,
  output logic                    col_tone,
  output logic                    tone_active,
  output logic                    busy,
  output logic                    done
);

  localparam int MS_MAX = (TONE_MS > GAP_MS) ? TONE_MS : GAP_MS;
  localparam int MS_W   = $clog2(MS_MAX + 1);
  localparam int PRE_W  = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;

  localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(MS_DIV - 1);
  localparam logic [MS_W-1:0]  TONE_LAST = MS_W'(TONE_MS - 1);
  localparam logic [MS_W-1:0]  GAP_LAST  = MS_W'(GAP_MS - 1);

  localparam logic [9:0] ROW_TBL [4] = '{row_half(CLK_HZ, 0), row_half(CLK_HZ, 1),
                                         row_half(CLK_HZ, 2), row_half(CLK_HZ, 3)};
  localparam logic [9:0] COL_TBL [4] = '{col_half(CLK_HZ, 0), col_half(CLK_HZ, 1),
                                         col_half(CLK_HZ, 2), col_half(CLK_HZ, 3)};

  state_t           state;
  logic [PRE_W-1:0] pre;
  logic [MS_W-1:0]  ms_cnt;
  logic [9:0]       row_half_q;
  logic [9:0]       col_half_q;
  logic             ms_tick;
  logic             div_en;
  logic             row_div;
  logic             col_div;

  assign key.key_ready = (state == ST_IDLE) & ~abort;
  assign ms_tick       = (pre == PRE_LAST);
  assign div_en        = (state == ST_TONE);

  // The dividers see the state change one edge late, so gate with tone_active to keep the
  // pins silent from the very first GAP/IDLE cycle.
  assign row_tone = row_div & tone_active;
  assign col_tone = col_div & tone_active;

  always_ff @(posedge inclk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      pre         <= '0;
      ms_cnt      <= '0;
      row_half_q  <= '0;
      col_half_q  <= '0;
      tone_active <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (key.key_valid && key.key_ready) begin
            state       <= ST_TONE;
            row_half_q  <= ROW_TBL[key_row(key.key_code)];
            col_half_q  <= COL_TBL[key_col(key.key_code)];
            pre         <= '0;
            ms_cnt      <= '0;
            tone_active <= 1'b1;
            busy        <= 1'b1;
          end
        end
        ST_TONE: begin
          if (abort) begin
            state       <= ST_IDLE;
            pre         <= '0;
            ms_cnt      <= '0;
            tone_active <= 1'b0;
            busy        <= 1'b0;
          end else if (ms_tick && ms_cnt == TONE_LAST) begin
            state       <= ST_GAP;
            pre         <= '0;
            ms_cnt      <= '0;
            tone_active <= 1'b0;
          end else begin
            pre <= ms_tick ? '0 : pre + PRE_W'(1);
            if (ms_tick) ms_cnt <= ms_cnt + MS_W'(1);
          end
        end
        ST_GAP: begin
          if (abort) begin
            state  <= ST_IDLE;
            pre    <= '0;
            ms_cnt <= '0;
            busy   <= 1'b0;
          end else if (ms_tick && ms_cnt == GAP_LAST) begin
            state  <= ST_IDLE;
            pre    <= '0;
            ms_cnt <= '0;
            busy   <= 1'b0;
            done   <= 1'b1;
          end else begin
            pre <= ms_tick ? '0 : pre + PRE_W'(1);
            if (ms_tick) ms_cnt <= ms_cnt + MS_W'(1);
          end
        end
        default: begin
          state       <= ST_IDLE;
          tone_active <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

  tone_divider u_row_div (
    .inclk   (inclk),
    .reset_n (reset_n),
    .en      (div_en),
    .half    (row_half_q),
    .tone    (row_div)
  );

  tone_divider u_col_div (
    .inclk   (inclk),
    .reset_n (reset_n),
    .en      (div_en),
    .half    (col_half_q),
    .tone    (col_div)
  );

endmodule

// File: tb/tb_dtmf_tone_sequencer.sv
// Directed bench for dtmf_tone_sequencer with shortened intervals:
// MS_DIV=100, TONE_MS=30, GAP_MS=10 -> tone 3000 clocks, gap 1000, done at +4000.
// Half-period tables stay at the 1 MHz values.
module tb_dtmf_tone_sequencer;

  localparam int MS_DIV  = 100;
  localparam int TONE_MS = 30;
  localparam int GAP_MS  = 10;

  logic inclk   = 1'b0;
  logic reset_n = 1'b0;
  logic abort   = 1'b0;
  logic row_tone, col_tone, tone_active, busy, done;

  dtmf_tone_sequencer_if kif ();

  dtmf_tone_sequencer #(
    .CLK_HZ  (1000000),
    .MS_DIV  (MS_DIV),
    .TONE_MS (TONE_MS),
    .GAP_MS  (GAP_MS)
  ) dut (
    .inclk       (inclk),
    .reset_n     (reset_n),
    .key         (kif),
    .abort       (abort),
    .row_tone    (row_tone),
    .col_tone    (col_tone),
    .tone_active (tone_active),
    .busy        (busy),
    .done        (done)
  );

  always #5 inclk = ~inclk;

  int n_checks = 0;
  int n_fail   = 0;

  // Filled by watch(): cycle offsets relative to the acceptance edge (k=0).
  int row_rise [2];
  int col_rise [2];
  int row_nr, col_nr, first_row, act_cnt, busy_cnt, done_cnt, done_at, gap_bad;

  // Offer a key for one edge; returns #1 after the accepting edge (k=0).
  task automatic send_key(input logic [3:0] k);
    kif.key_code  = k;
    kif.key_valid = 1'b1;
    @(posedge inclk); #1;
    kif.key_valid = 1'b0;
  endtask

  // Sample outputs at k=0 (now) and after each of the next ncyc edges.
  task automatic watch(input int ncyc);
    logic pr, pc;
    row_rise = '{-1, -1}; col_rise = '{-1, -1};
    row_nr = 0; col_nr = 0; first_row = -1; done_at = -1; gap_bad = 0;
    act_cnt  = tone_active ? 1 : 0;
    busy_cnt = busy ? 1 : 0;
    done_cnt = done ? 1 : 0;
    pr = row_tone; pc = col_tone;
    for (int k = 1; k <= ncyc; k++) begin
      @(posedge inclk); #1;
      if (row_tone !== pr && first_row < 0) first_row = k;
      if (row_tone && !pr) begin if (row_nr < 2) row_rise[row_nr] = k; row_nr++; end
      if (col_tone && !pc) begin if (col_nr < 2) col_rise[col_nr] = k; col_nr++; end
      if (tone_active) act_cnt++;
      if (busy) busy_cnt++;
      if (!tone_active && (row_tone || col_tone)) gap_bad++;
      if (done) begin done_cnt++; done_at = k; end
      pr = row_tone; pc = col_tone;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) @(posedge inclk); #1;
    n_checks++; if (kif.key_ready !== 1'b1) begin n_fail++; $display("FAIL reset_key_ready got %b want 1", kif.key_ready); end
    n_checks++; if (tone_active !== 1'b0) begin n_fail++; $display("FAIL reset_tone_active got %b want 0", tone_active); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++; if ({row_tone, col_tone} !== 2'b00) begin n_fail++; $display("FAIL reset_tones got %b want 00", {row_tone, col_tone}); end
    #3 reset_n = 1'b1;
    @(posedge inclk); #1;
    n_checks++; if (kif.key_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_release got ready=%b busy=%b want 1/0", kif.key_ready, busy); end
  endtask

  task automatic test_key_1();
    send_key(4'h0);
    n_checks++; if (tone_active !== 1'b1 || kif.key_ready !== 1'b0) begin n_fail++; $display("FAIL k1_accept got act=%b rdy=%b want 1/0", tone_active, kif.key_ready); end
    watch(4100);
    n_checks++; if (row_rise[0] !== 717) begin n_fail++; $display("FAIL k1_row_first got %0d want 717", row_rise[0]); end
    n_checks++; if (row_rise[1] - row_rise[0] !== 1434) begin n_fail++; $display("FAIL k1_row_period got %0d want 1434", row_rise[1] - row_rise[0]); end
    n_checks++; if (col_rise[0] !== 414) begin n_fail++; $display("FAIL k1_col_first got %0d want 414", col_rise[0]); end
    n_checks++; if (col_rise[1] - col_rise[0] !== 828) begin n_fail++; $display("FAIL k1_col_period got %0d want 828", col_rise[1] - col_rise[0]); end
    n_checks++; if (act_cnt !== 3000) begin n_fail++; $display("FAIL k1_tone_len got %0d want 3000", act_cnt); end
    n_checks++; if (busy_cnt !== 4000) begin n_fail++; $display("FAIL k1_busy_len got %0d want 4000", busy_cnt); end
    n_checks++; if (gap_bad !== 0) begin n_fail++; $display("FAIL k1_gap_silent got %0d noisy cycles want 0", gap_bad); end
    n_checks++; if (done_cnt !== 1 || done_at !== 4000) begin n_fail++; $display("FAIL k1_done got cnt=%0d at=%0d want 1 at 4000", done_cnt, done_at); end
  endtask

  task automatic test_key_d();
    send_key(4'hF);
    watch(4100);
    n_checks++; if (first_row !== 531) begin n_fail++; $display("FAIL kd_row_first_edge got %0d want 531", first_row); end
    n_checks++; if (row_rise[1] - row_rise[0] !== 1062) begin n_fail++; $display("FAIL kd_row_period got %0d want 1062", row_rise[1] - row_rise[0]); end
    n_checks++; if (col_rise[0] !== 306) begin n_fail++; $display("FAIL kd_col_first got %0d want 306", col_rise[0]); end
    n_checks++; if (col_rise[1] - col_rise[0] !== 612) begin n_fail++; $display("FAIL kd_col_period got %0d want 612", col_rise[1] - col_rise[0]); end
    n_checks++; if (done_at !== 4000) begin n_fail++; $display("FAIL kd_done_at got %0d want 4000", done_at); end
  endtask

  task automatic test_abort();
    send_key(4'h0);
    repeat (1300) @(posedge inclk); #1;
    // row: 717 up; col: 414 up, 828 down, 1242 up
    n_checks++; if ({row_tone, col_tone} !== 2'b11) begin n_fail++; $display("FAIL ab_pre_tones got %b want 11", {row_tone, col_tone}); end
    abort = 1'b1;
    @(posedge inclk); #1;
    n_checks++; if ({row_tone, col_tone} !== 2'b00) begin n_fail++; $display("FAIL ab_tones got %b want 00", {row_tone, col_tone}); end
    n_checks++; if (tone_active !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL ab_state got act=%b busy=%b want 0/0", tone_active, busy); end
    n_checks++; if (kif.key_ready !== 1'b0) begin n_fail++; $display("FAIL ab_ready_held got %b want 0", kif.key_ready); end
    abort = 1'b0;
    #1;
    n_checks++; if (kif.key_ready !== 1'b1) begin n_fail++; $display("FAIL ab_ready_return got %b want 1", kif.key_ready); end
    watch(4100);
    n_checks++; if (done_cnt !== 0 || act_cnt !== 0) begin n_fail++; $display("FAIL ab_no_done got done=%0d act=%0d want 0/0", done_cnt, act_cnt); end
  endtask

  task automatic test_reset_mid();
    send_key(4'h5);
    repeat (700) @(posedge inclk); #1;
    // row half 649 (up at 649), col half 374 (up 374, down 748)
    n_checks++; if ({row_tone, col_tone} !== 2'b11) begin n_fail++; $display("FAIL rm_pre_tones got %b want 11", {row_tone, col_tone}); end
    #3 reset_n = 1'b0;
    #1;
    n_checks++; if ({row_tone, col_tone, tone_active, busy} !== 4'b0000) begin n_fail++; $display("FAIL rm_async_clear got %b want 0000", {row_tone, col_tone, tone_active, busy}); end
    n_checks++; if (kif.key_ready !== 1'b1) begin n_fail++; $display("FAIL rm_ready_in_reset got %b want 1", kif.key_ready); end
    #2 reset_n = 1'b1;
    @(posedge inclk); #1;
    n_checks++; if (kif.key_ready !== 1'b1 || busy !== 1'b0 || tone_active !== 1'b0) begin n_fail++; $display("FAIL rm_after_release got rdy=%b busy=%b act=%b want 1/0/0", kif.key_ready, busy, tone_active); end
  endtask

  task automatic test_back_to_back();
    logic pr, pc, pa;
    int d_at, acc2, row1, r2, c1, c2;
    d_at = -1; acc2 = -1; row1 = -1; r2 = -1; c1 = -1; c2 = -1;
    kif.key_code  = 4'h5;
    kif.key_valid = 1'b1;
    @(posedge inclk); #1;
    kif.key_code = 4'hD;
    pr = row_tone; pc = col_tone; pa = tone_active;
    for (int k = 1; k <= 5800; k++) begin
      @(posedge inclk); #1;
      if (done && d_at < 0) d_at = k;
      if (tone_active && !pa && acc2 < 0) acc2 = k;
      if (acc2 < 0 && row_tone && !pr && row1 < 0) row1 = k;
      if (acc2 >= 0 && row_tone !== pr && r2 < 0) r2 = k - acc2;
      if (acc2 >= 0 && col_tone && !pc) begin
        if (c1 < 0) c1 = k - acc2;
        else if (c2 < 0) c2 = k - acc2;
      end
      pr = row_tone; pc = col_tone; pa = tone_active;
    end
    kif.key_valid = 1'b0;
    n_checks++; if (row1 !== 649) begin n_fail++; $display("FAIL bb_first_row got %0d want 649", row1); end
    n_checks++; if (d_at !== 4000) begin n_fail++; $display("FAIL bb_done_at got %0d want 4000", d_at); end
    n_checks++; if (acc2 !== 4001) begin n_fail++; $display("FAIL bb_second_accept got %0d want 4001", acc2); end
    // key 0xD = row 3 (941 Hz, half 531), col 1 (1336 Hz, half 374)
    n_checks++; if (r2 !== 531) begin n_fail++; $display("FAIL bb_second_row got %0d want 531", r2); end
    n_checks++; if (c1 !== 374 || c2 - c1 !== 748) begin n_fail++; $display("FAIL bb_second_col got first=%0d period=%0d want 374/748", c1, c2 - c1); end
    abort = 1'b1;
    @(posedge inclk); #1;
    abort = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL bb_abort_idle got busy=%b want 0", busy); end
  endtask

  task automatic test_gap_ignore();
    int d_at, restarts;
    d_at = -1; restarts = 0;
    send_key(4'h0);
    repeat (3500) @(posedge inclk); #1;
    n_checks++; if (kif.key_ready !== 1'b0 || busy !== 1'b1 || tone_active !== 1'b0) begin n_fail++; $display("FAIL gi_in_gap got rdy=%b busy=%b act=%b want 0/1/0", kif.key_ready, busy, tone_active); end
    kif.key_code  = 4'hF;
    kif.key_valid = 1'b1;
    repeat (3) @(posedge inclk); #1;
    n_checks++; if (kif.key_ready !== 1'b0 || tone_active !== 1'b0) begin n_fail++; $display("FAIL gi_pulse_ignored got rdy=%b act=%b want 0/0", kif.key_ready, tone_active); end
    kif.key_valid = 1'b0;
    for (int k = 3504; k <= 4030; k++) begin
      @(posedge inclk); #1;
      if (done && d_at < 0) d_at = k;
      if (tone_active) restarts++;
    end
    n_checks++; if (d_at !== 4000) begin n_fail++; $display("FAIL gi_done_at got %0d want 4000", d_at); end
    n_checks++; if (restarts !== 0) begin n_fail++; $display("FAIL gi_no_restart got %0d active cycles want 0", restarts); end
  endtask

  initial begin
    kif.key_code  = 4'h0;
    kif.key_valid = 1'b0;
    test_reset();
    test_key_1();
    test_key_d();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_gap_ignore();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired before test sequence completed");
    $fatal(1, "watchdog");
  end

endmodule
